// File: rtl/led_pio_pkg.sv
// Shared register map and CTRL bit positions for the LED PIO controller.
package led_pio_pkg;

   localparam logic [2:0] ADDR_DATA         = 3'd0;
   localparam logic [2:0] ADDR_SET          = 3'd1;
   localparam logic [2:0] ADDR_CLEAR        = 3'd2;
   localparam logic [2:0] ADDR_TOGGLE       = 3'd3;
   localparam logic [2:0] ADDR_BLINK_EN     = 3'd4;
   localparam logic [2:0] ADDR_BLINK_PERIOD = 3'd5;
   localparam logic [2:0] ADDR_DUTY         = 3'd6;
   localparam logic [2:0] ADDR_CTRL         = 3'd7;

   localparam int CTRL_RUN   = 0;
   localparam int CTRL_PHASE = 1;

endpackage

// File: rtl/led_pio_ctrl_if.sv
// Avalon-MM slave bus bundle for the LED PIO controller.
interface led_pio_ctrl_if;
   logic [2:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;

   modport master (output address, chipselect, write_n, writedata, input readdata);
   modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/led_pio_timebase.sv
// Blink timebase: prescaler producing a tick, and a half-period counter toggling blink_phase.
module led_pio_timebase #(
   parameter int PRESCALE = 50000,
   parameter int PERIOD_W = 16
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                run,
   input  logic [PERIOD_W-1:0] period,
   input  logic                period_wr,
   output logic                tick,
   output logic                blink_phase
);

   localparam int                PRE_W    = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
   localparam logic [PRE_W-1:0]  PRE_LAST = PRE_W'(PRESCALE - 1);

   logic [PRE_W-1:0]    pre_cnt;
   logic [PERIOD_W-1:0] blink_cnt;

   assign tick = run && (pre_cnt == PRE_LAST);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pre_cnt     <= '0;
         blink_cnt   <= '0;
         blink_phase <= 1'b1;
      end else if (!run) begin
         pre_cnt     <= '0;
         blink_cnt   <= '0;
         blink_phase <= 1'b1;
      end else begin
         pre_cnt <= tick ? '0 : pre_cnt + PRE_W'(1);
         // A period rewrite restarts the blink cleanly, even on a tick edge.
         if (period_wr || (period == '0)) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b1;
         end else if (tick) begin
            if (blink_cnt == period - PERIOD_W'(1)) begin
               blink_cnt   <= '0;
               blink_phase <= ~blink_phase;
            end else begin
               blink_cnt <= blink_cnt + PERIOD_W'(1);
            end
         end
      end
   end

endmodule

// File: rtl/led_pio_ctrl.sv
// LED bank output PIO: DATA with set/clear/toggle aliases, per-channel blink and global PWM dimming.
module led_pio_ctrl
   import led_pio_pkg::*;
#(
   parameter int               WIDTH       = 4,
   parameter int               PRESCALE    = 50000,
   parameter int               PERIOD_W    = 16,
   parameter int               PWM_W       = 8,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
   input  logic              clk,
   input  logic              reset,
   led_pio_ctrl_if.slave     bus,
   output logic [WIDTH-1:0]  out_port
);

   localparam logic [PWM_W-1:0] DUTY_FULL = {PWM_W{1'b1}};

   logic [WIDTH-1:0]    data;
   logic [WIDTH-1:0]    blink_en;
   logic [PERIOD_W-1:0] period;
   logic [PWM_W-1:0]    duty;
   logic                run;
   logic [PWM_W-1:0]    pwm_cnt;
   logic                blink_phase;
   logic                blink_tick;
   logic                wr_en;
   logic                period_wr;
   logic                pwm_on;
   logic [WIDTH-1:0]    wd_w;
   logic [WIDTH-1:0]    nxt;

   assign wr_en     = bus.chipselect && !bus.write_n;
   assign period_wr = wr_en && (bus.address == ADDR_BLINK_PERIOD);
   assign wd_w      = bus.writedata[WIDTH-1:0];

   led_pio_timebase #(
      .PRESCALE (PRESCALE),
      .PERIOD_W (PERIOD_W)
   ) u_timebase (
      .clk         (clk),
      .reset       (reset),
      .run         (run),
      .period      (period),
      .period_wr   (period_wr),
      .tick        (blink_tick),
      .blink_phase (blink_phase)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         data     <= RESET_VALUE;
         blink_en <= '0;
         period   <= '0;
         duty     <= DUTY_FULL;
         run      <= 1'b1;
      end else if (wr_en) begin
         case (bus.address)
            ADDR_DATA:         data     <= wd_w;
            ADDR_SET:          data     <= data | wd_w;
            ADDR_CLEAR:        data     <= data & ~wd_w;
            ADDR_TOGGLE:       data     <= data ^ wd_w;
            ADDR_BLINK_EN:     blink_en <= wd_w;
            ADDR_BLINK_PERIOD: period   <= bus.writedata[PERIOD_W-1:0];
            ADDR_DUTY:         duty     <= bus.writedata[PWM_W-1:0];
            ADDR_CTRL:         run      <= bus.writedata[CTRL_RUN];
            default:           ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pwm_cnt <= '0;
      end else if (!run) begin
         pwm_cnt <= '0;
      end else begin
         pwm_cnt <= pwm_cnt + PWM_W'(1);
      end
   end

   // Full-scale duty must be solid on, not on for all but one count.
   assign pwm_on = !run || (duty == DUTY_FULL) || (pwm_cnt < duty);
   assign nxt    = data & (~blink_en | {WIDTH{blink_phase}}) & {WIDTH{pwm_on}};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_port <= '0;
      end else begin
         out_port <= nxt;
      end
   end

   always_comb begin
      bus.readdata = '0;
      case (bus.address)
         ADDR_DATA, ADDR_SET, ADDR_CLEAR, ADDR_TOGGLE: bus.readdata[WIDTH-1:0] = data;
         ADDR_BLINK_EN:     bus.readdata[WIDTH-1:0]    = blink_en;
         ADDR_BLINK_PERIOD: bus.readdata[PERIOD_W-1:0] = period;
         ADDR_DUTY:         bus.readdata[PWM_W-1:0]    = duty;
         ADDR_CTRL: begin
            bus.readdata[CTRL_RUN]   = run;
            bus.readdata[CTRL_PHASE] = blink_phase;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_led_pio_ctrl.sv
// Bench for led_pio_ctrl: directed scenarios plus random bus traffic against an arithmetic model.
module tb_led_pio_ctrl;
   import led_pio_pkg::*;

   localparam int             W    = 4;
   localparam int             PS   = 4;
   localparam int             PW   = 16;
   localparam int             PWMW = 4;
   localparam logic [W-1:0]   RV   = 4'h6;

   logic         clk = 1'b0;
   logic         reset = 1'b0;
   logic [W-1:0] out_port;
   int           n_checks = 0;
   int           n_fail = 0;
   bit           chk_en = 1'b0;

   led_pio_ctrl_if bus ();

   led_pio_ctrl #(
      .WIDTH       (W),
      .PRESCALE    (PS),
      .PERIOD_W    (PW),
      .PWM_W       (PWMW),
      .RESET_VALUE (RV)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .bus      (bus.slave),
      .out_port (out_port)
   );

   always #5 clk = ~clk;

   // Model: counters are expressed as elapsed running edges since the last hold,
   // and blink phase as the parity of whole half-periods since the last period write.
   logic [W-1:0] m_data, m_ben, exp_out;
   logic [3:0]   m_duty;
   logic         m_run;
   int unsigned  m_period;
   int           run_cyc, anchor;
   logic         pwm_on_m;

   function automatic logic m_phase();
      if (m_period == 0) return 1'b1;
      return ((((run_cyc / PS) - anchor) / int'(m_period)) % 2) == 0;
   endfunction

   function automatic logic [31:0] m_read(input logic [2:0] a);
      case (a)
         3'd0, 3'd1, 3'd2, 3'd3: return 32'(m_data);
         3'd4:                   return 32'(m_ben);
         3'd5:                   return 32'(m_period);
         3'd6:                   return 32'(m_duty);
         default:                return {30'd0, m_phase(), m_run};
      endcase
   endfunction

   function automatic logic [31:0] rst_read(input int a);
      if (a < 4)  return 32'(RV);
      if (a == 6) return 32'h0000_000F;
      if (a == 7) return 32'h0000_0003;
      return 32'h0;
   endfunction

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_data = RV; m_ben = '0; m_period = 0; m_duty = 4'hF; m_run = 1'b1;
         run_cyc = 0; anchor = 0; exp_out = '0;
      end else begin
         pwm_on_m = !m_run || (m_duty == 4'hF) || ((run_cyc % (1 << PWMW)) < int'(m_duty));
         exp_out  = m_data & (~m_ben | {W{m_phase()}}) & {W{pwm_on_m}};
         if (m_run) run_cyc++;
         else begin run_cyc = 0; anchor = 0; end
         if (bus.chipselect && !bus.write_n) begin
            case (bus.address)
               3'd0: m_data = bus.writedata[W-1:0];
               3'd1: m_data = m_data | bus.writedata[W-1:0];
               3'd2: m_data = m_data & ~bus.writedata[W-1:0];
               3'd3: m_data = m_data ^ bus.writedata[W-1:0];
               3'd4: m_ben  = bus.writedata[W-1:0];
               3'd5: begin m_period = bus.writedata[PW-1:0]; anchor = run_cyc / PS; end
               3'd6: m_duty = bus.writedata[PWMW-1:0];
               default: m_run = bus.writedata[0];
            endcase
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      #1;
      if (chk_en) begin
         chk("out_port", 32'(out_port), 32'(exp_out));
         chk("readdata", bus.readdata, m_read(bus.address));
      end
   end

   task automatic wr_now(input logic [2:0] a, input logic [31:0] d);
      bus.address = a; bus.writedata = d; bus.chipselect = 1'b1; bus.write_n = 1'b0;
      @(negedge clk); #2;
      bus.chipselect = 1'b0; bus.write_n = 1'b1;
   endtask

   task automatic wr(input logic [2:0] a, input logic [31:0] d);
      @(negedge clk); #2;
      wr_now(a, d);
   endtask

   task automatic idle(input int n, input logic [2:0] a);
      repeat (n) begin @(negedge clk); #2; bus.address = a; end
   endtask

   task automatic wr_chk(input logic [2:0] a, input logic [31:0] d, input logic [W-1:0] exp);
      wr(a, d);
      bus.address = ADDR_DATA;
      #1 chk("data_rd", bus.readdata, 32'(exp));
      @(negedge clk); #2;
      chk("data_out", 32'(out_port), 32'(exp));
   endtask

   task automatic count_bit0(input int n, output int cnt);
      cnt = 0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk); #2;
         if (out_port[0]) cnt++;
      end
   endtask

   task automatic do_reset_check(input string tag);
      #1;
      chk({tag, "_out"}, 32'(out_port), 32'h0);
      for (int a = 0; a < 8; a++) begin
         bus.address = 3'(a);
         #1 chk({tag, "_rd"}, bus.readdata, rst_read(a));
      end
   endtask

   initial begin
      int cnt, togg, bad;
      logic prev;
      bit found;
      bus.address = '0; bus.chipselect = 1'b0; bus.write_n = 1'b1; bus.writedata = '0;

      #1 reset = 1'b1;
      do_reset_check("rst");
      repeat (2) @(negedge clk);
      #3 reset = 1'b0;
      chk_en = 1'b1;
      @(negedge clk); #2;
      chk("post_rst_out", 32'(out_port), 32'(RV));

      // register aliases, upper writedata bits ignored
      wr_chk(ADDR_DATA,   32'hFFFF_FFFA, 4'hA);
      wr_chk(ADDR_SET,    32'h0000_0005, 4'hF);
      wr_chk(ADDR_CLEAR,  32'h0000_0003, 4'hC);
      wr_chk(ADDR_TOGGLE, 32'hFFF0_0009, 4'h5);

      // blink on channel 0: toggles every 2 ticks of 4 clk
      wr(ADDR_DATA, 32'hF); wr(ADDR_BLINK_EN, 32'h1); wr(ADDR_BLINK_PERIOD, 32'h2);
      idle(4, ADDR_CTRL);
      togg = 0; bad = 0; prev = out_port[0];
      for (int i = 0; i < 32; i++) begin
         @(negedge clk); #2;
         if (out_port[0] != prev) togg++;
         if (out_port[3:1] != 3'b111) bad++;
         prev = out_port[0];
      end
      chk("blink_toggles", togg, 4);
      chk("blink_steady_hi", bad, 0);

      // period write coinciding with a tick
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         @(negedge clk); #2;
         if ((run_cyc % PS) == PS - 1) found = 1'b1;
      end
      chk("tick_found", 32'(found), 32'h1);
      wr_now(ADDR_BLINK_PERIOD, 32'h3);
      bus.address = ADDR_CTRL;
      cnt = 0;
      for (int i = 0; i < 12; i++) begin
         #1 if (bus.readdata[CTRL_PHASE]) cnt++;
         @(negedge clk); #1;
      end
      chk("phase_hold12", cnt, 12);
      #1 chk("phase_toggle", 32'(bus.readdata[CTRL_PHASE]), 32'h0);

      wr(ADDR_BLINK_PERIOD, 32'h0);
      idle(1, ADDR_CTRL);
      count_bit0(20, cnt);
      chk("period0_on", cnt, 20);

      // PWM dimming
      wr(ADDR_BLINK_EN, 32'h0); wr(ADDR_DATA, 32'h1); wr(ADDR_DUTY, 32'h4);
      idle(2, ADDR_DUTY);
      count_bit0(16, cnt);  chk("pwm_duty4", cnt, 4);
      wr(ADDR_DUTY, 32'h0); idle(2, ADDR_DUTY);
      count_bit0(16, cnt);  chk("pwm_duty0", cnt, 0);
      wr(ADDR_DUTY, 32'hF); idle(2, ADDR_DUTY);
      count_bit0(16, cnt);  chk("pwm_full", cnt, 16);

      // run=0 bypasses blink and PWM
      wr(ADDR_DUTY, 32'h0); wr(ADDR_BLINK_EN, 32'hF); wr(ADDR_BLINK_PERIOD, 32'h1);
      wr(ADDR_DATA, 32'h5); wr(ADDR_CTRL, 32'h0);
      idle(1, ADDR_CTRL);
      cnt = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk); #2;
         if (out_port == 4'h5) cnt++;
      end
      chk("run0_direct", cnt, 10);
      wr(ADDR_CTRL, 32'h1);

      // random traffic
      for (int i = 0; i < 400; i++) begin
         logic [2:0]  a;
         logic [31:0] d;
         a = 3'($urandom_range(0, 7));
         d = $urandom;
         if (a == ADDR_BLINK_PERIOD) d = (d & 32'hFFFF_0000) | 32'($urandom_range(0, 3));
         if (a == ADDR_CTRL)         d = (d & 32'hFFFF_FFFE) | 32'($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 9) < 4) wr(a, d);
         else idle(1, a);
      end

      // reset mid-blink
      wr(ADDR_DATA, 32'hF); wr(ADDR_BLINK_EN, 32'hF); wr(ADDR_BLINK_PERIOD, 32'h1);
      wr(ADDR_DUTY, 32'hF); wr(ADDR_CTRL, 32'h1);
      idle(6, ADDR_CTRL);
      @(negedge clk);
      chk_en = 1'b0;
      #3 reset = 1'b1;
      do_reset_check("midrst");
      @(negedge clk);
      #3 reset = 1'b0;
      chk_en = 1'b1;
      idle(8, ADDR_CTRL);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
